word32_8bits: RTL

WORD32_8BITS -- requirements
Module: word32_8bits

---
 rtl/word32_8bits_pkg.sv | 27 ++
 rtl/word32_8bits_if.sv | 19 +
 rtl/word_skid_reg.sv | 31 +++
 rtl/word32_8bits.sv | 119 +++++++++++
 4 files changed

// File: rtl/word32_8bits_pkg.sv
// Shared types for the 8b/32b converters: FSM states, byte counter and a
// byte-lane selector honouring the configured byte order.
package word32_8bits_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam int unsigned CNT_W = 2;

  typedef logic [CNT_W-1:0] cnt_t;

  // Byte 'idx' of a word in transmit order; idx 0 is the first byte sent.
  function automatic logic [7:0] pick_byte(input logic [31:0] w, input cnt_t idx,
                                           input bit msb_first);
    cnt_t sel;
    sel = msb_first ? cnt_t'(~idx) : idx;
    case (sel)
      2'd0:    return w[7:0];
      2'd1:    return w[15:8];
      2'd2:    return w[23:16];
      default: return w[31:24];
    endcase
  endfunction

endpackage

// File: rtl/word32_8bits_if.sv
// Word-in / byte-out handshake bundle for word32_8bits.
interface word32_8bits_if;
  logic        valid_in;
  logic [31:0] Data_in;
  logic        ready_in;
  logic        valid_out;
  logic [7:0]  Data_out;
  logic        busy;

  modport master (
    output valid_in, Data_in,
    input  ready_in, valid_out, Data_out, busy
  );

  modport slave (
    input  valid_in, Data_in,
    output ready_in, valid_out, Data_out, busy
  );
endinterface

// File: rtl/word_skid_reg.sv
// One-word holding register with a full flag: written on load, emptied on take.
module word_skid_reg #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic         i_take,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_data,
  output logic         o_full
);

  logic [W-1:0] r_data;
  logic         r_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
      r_full <= 1'b0;
    end else begin
      if (i_load) r_data <= i_data;
      if (i_load)      r_full <= 1'b1;
      else if (i_take) r_full <= 1'b0;
    end
  end

  assign o_data = r_data;
  assign o_full = r_full;

endmodule

// File: rtl/word32_8bits.sv
// 32-bit word to 8-bit byte serializer: one byte per clk_4f, one word of
// look-ahead storage so back-to-back words stream without bubbles.
module word32_8bits
  import word32_8bits_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
) (
  input logic           clk_4f,
  input logic           reset,
  word32_8bits_if.slave bus
);

  state_t      r_state, w_state_nxt;
  cnt_t        r_cnt, w_cnt_nxt;
  logic [31:0] r_active, w_active_nxt;
  logic        r_have_next, w_have_nxt;
  logic        r_valid, w_valid_nxt;
  logic [7:0]  r_dout, w_dout_nxt;

  logic        w_pend_full;
  logic [31:0] w_pend_data;
  logic        w_load;
  logic        w_take;
  logic        w_accept;

  assign w_accept = bus.valid_in & ~w_pend_full;

  word_skid_reg #(.W(32)) u_skid (
    .clk    (clk_4f),
    .rst    (reset),
    .i_load (w_load),
    .i_take (w_take),
    .i_data (bus.Data_in),
    .o_data (w_pend_data),
    .o_full (w_pend_full)
  );

  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_active    <= '0;
      r_have_next <= 1'b0;
      r_valid     <= 1'b0;
      r_dout      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_active    <= w_active_nxt;
      r_have_next <= w_have_nxt;
      r_valid     <= w_valid_nxt;
      r_dout      <= w_dout_nxt;
    end
  end

  // cnt==0 in SEND is the word boundary: the next word (if any) was latched
  // into r_active on the byte-3 edge and its byte 0 goes out now.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_active_nxt = r_active;
    w_have_nxt   = r_have_next;
    w_valid_nxt  = r_valid;
    w_dout_nxt   = r_dout;
    w_load       = 1'b0;
    w_take       = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (w_pend_full || w_accept) begin
          w_take       = w_pend_full;
          w_active_nxt = w_pend_full ? w_pend_data : bus.Data_in;
          w_dout_nxt   = pick_byte(w_active_nxt, '0, MSB_FIRST);
          w_valid_nxt  = 1'b1;
          w_cnt_nxt    = cnt_t'(1);
          w_state_nxt  = SEND;
        end
      end
      SEND: begin
        if (r_cnt == '0) begin
          if (r_have_next) begin
            w_dout_nxt  = pick_byte(r_active, '0, MSB_FIRST);
            w_valid_nxt = 1'b1;
            w_cnt_nxt   = cnt_t'(1);
            w_have_nxt  = 1'b0;
          end else begin
            w_dout_nxt  = '0;
            w_valid_nxt = 1'b0;
            w_state_nxt = IDLE;
          end
          w_load = w_accept;
        end else begin
          w_dout_nxt  = pick_byte(r_active, r_cnt, MSB_FIRST);
          w_valid_nxt = 1'b1;
          w_cnt_nxt   = r_cnt + cnt_t'(1);
          if (r_cnt == '1) begin
            if (w_pend_full) begin
              w_take       = 1'b1;
              w_active_nxt = w_pend_data;
              w_have_nxt   = 1'b1;
            end else if (w_accept) begin
              w_active_nxt = bus.Data_in;
              w_have_nxt   = 1'b1;
            end
          end else begin
            w_load = w_accept;
          end
        end
      end
      default: ;
    endcase
  end

  assign bus.ready_in  = ~w_pend_full;
  assign bus.valid_out = r_valid;
  assign bus.Data_out  = r_dout;
  assign bus.busy      = (r_state == SEND) | w_pend_full;

endmodule
